syndrome_calc: RTL and testbench
================================

Name: syndrome_calc

Overview:
- Computes the binary syndrome s = H·e (GF(2)) of an N_ERR-bit error/received vector. This is the forward direction of the decoder's linear-system solve.
- Streams the parity-check matrix H one column per cycle from an external synchronous column memory, with 1-cycle read latency.
- XOR-accumulates each selected column into a RANK_MAX-bit syndrome register.
- Used for two purposes: producing syndromes for the solver, and re-checking the solver's e_hat (syndrome of e_hat must match).

Parameters:
- RANK_MAX, 936, number of syndrome rows (width of one H column).
- N_ERR, 8784, length of the error vector (number of H columns).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new computation; sampled only in IDLE or DONE.
- e_in  input  N_ERR  error vector; bit k selects column k. Latched on accepted start.
- n_cols_in  input  $clog2(N_ERR+1)  number of columns to process (0..N_ERR). Latched on start.
- rank_in  input  $clog2(RANK_MAX+1)  active rows. Syndrome bits at index ≥ rank_in are forced 0. Latched on start.
- col_addr  output  $clog2(N_ERR)  column read address.
- col_rd_en  output  1  column read strobe.
- col_data  input  RANK_MAX  H column; valid the cycle after col_rd_en; bit r = row r, LSB = row 0.
- syndrome  output  RANK_MAX  result; bit r = row r.
- err_weight  output  $clog2(N_ERR+1)  count of ones in e_in[n_cols_in-1:0].
- busy  output  1  high from the cycle after start acceptance until done rises.
- done  output  1  result valid; held high until the next accepted start.

Behaviour:
- Reset values: syndrome=0, err_weight=0, busy=0, done=0, col_rd_en=0, col_addr=0, state=IDLE.
- rst asserted mid-operation aborts at the next edge to IDLE. No partial result is retained.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE, start=1 (cycle T):
  - latch e_in, n_cols_in, rank_in;
  - clear syndrome, err_weight, done;
  - set k=0 and busy=1;
  - next state = RUN if n_cols_in>0, else DONE with done=1 at T+1.
- RUN (cycles T+1..T+n):
  - drive col_rd_en=1, col_addr=k;
  - register pipeline tag sel_d=e_reg[k];
  - if k==n-1 go to DRAIN, else k++.
- Accumulate stage, active in RUN (from second cycle) and in DRAIN:
  - if sel_d=1: syndrome <= syndrome ^ (col_data & row_mask), and err_weight++;
  - row_mask bit r = (r < rank_in_reg).
- DRAIN (cycle T+n+1): col_rd_en=0, accumulate the last column, go to DONE, done=1.
- Fixed latency: done first high at T+n+2 for n>0, and at T+1 for n=0. Columns whose e bit is 0 still consume a cycle; there is no skipping.
- col_rd_en is 1 only in RUN. col_addr holds its last value when col_rd_en=0.
- start in RUN/DRAIN is ignored; no restart and no queueing.
- start in DONE restarts as from IDLE; done drops at the accept edge.
- rank_in_reg ≥ RANK_MAX means all rows are active. rank_in_reg=0 gives syndrome=0, but err_weight still counts.
- n_cols_in > N_ERR is clamped to N_ERR.
- Bits of e_in at index ≥ n_cols_in are ignored.

Test Plan (RANK_MAX=8, N_ERR=16; memory model returns col_data = k+1 for address k):
- e_in=16'h0005, n_cols_in=16, rank_in=8, start at T -> reads addr 0..15 on T+1..T+16; done at T+18; syndrome=8'h01^8'h03=8'h02; err_weight=2; busy high T+1..T+17.
- e_in=16'h4000, rank_in=4, n=16 -> col 14 data 8'h0F masked to 4 rows -> syndrome=8'h0F.
- e_in=16'h8000, rank_in=4, n=16 -> 8'h10 masked -> syndrome=8'h00; err_weight=1.
- e_in=16'hFFFF, n_cols_in=0 -> done at T+1; syndrome=0; err_weight=0; col_rd_en never asserts.
- e_in=16'hFFFF, n_cols_in=3 -> syndrome=1^2^3=8'h00; err_weight=3; done at T+5. A start pulse at T+2 is ignored.
- Run the first case; assert rst at T+5 -> all outputs zero at T+6, state IDLE. A new start then gives a full correct result.

Source files
------------

// File: rtl/syndrome_calc_if.sv
// Request/result and column-memory signals of syndrome_calc.
// slave: the syndrome engine; master: the requester plus the H column memory.
interface syndrome_calc_if #(
  parameter int RANK_MAX = 936,
  parameter int N_ERR    = 8784
) ();
  localparam int NW = $clog2(N_ERR + 1);
  localparam int AW = $clog2(N_ERR);
  localparam int RW = $clog2(RANK_MAX + 1);

  logic                start;
  logic [N_ERR-1:0]    e_in;
  logic [NW-1:0]       n_cols_in;
  logic [RW-1:0]       rank_in;
  logic [AW-1:0]       col_addr;
  logic                col_rd_en;
  logic [RANK_MAX-1:0] col_data;
  logic [RANK_MAX-1:0] syndrome;
  logic [NW-1:0]       err_weight;
  logic                busy;
  logic                done;

  modport slave (
    input  start, e_in, n_cols_in, rank_in, col_data,
    output col_addr, col_rd_en, syndrome, err_weight, busy, done
  );

  modport master (
    output start, e_in, n_cols_in, rank_in, col_data,
    input  col_addr, col_rd_en, syndrome, err_weight, busy, done
  );
endinterface

// File: rtl/syndrome_calc.sv
// GF(2) syndrome s = H*e, streaming one H column per cycle from a 1-cycle-latency memory.
// Fixed latency n+2 cycles from start to done (1 cycle when n=0); start ignored while busy.
module syndrome_calc #(
  parameter int RANK_MAX = 936,
  parameter int N_ERR    = 8784
) (
  input  logic            clk,
  input  logic            rst,
  syndrome_calc_if.slave  io
);
  localparam int NW = $clog2(N_ERR + 1);
  localparam int AW = $clog2(N_ERR);
  localparam int RW = $clog2(RANK_MAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [N_ERR-1:0]    e_reg;
  logic [NW-1:0]       n_reg;
  logic [RW-1:0]       rank_reg;
  logic [AW-1:0]       k;
  logic                sel_d;
  logic [RANK_MAX-1:0] syn_q;
  logic [NW-1:0]       wt_q;
  logic [RANK_MAX-1:0] row_mask;
  logic [NW-1:0]       n_clamp;
  logic                accept;
  logic                last;

  assign accept  = io.start && ((state_q == IDLE) || (state_q == DONE));
  assign n_clamp = (io.n_cols_in > NW'(N_ERR)) ? NW'(N_ERR) : io.n_cols_in;
  assign last    = (NW'(k) == (n_reg - NW'(1)));

  assign io.col_addr   = k;
  assign io.syndrome   = syn_q;
  assign io.err_weight = wt_q;

  always_comb begin
    row_mask = '0;
    for (int r = 0; r < RANK_MAX; r++) begin
      row_mask[r] = (RW'(r) < rank_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    io.col_rd_en = 1'b0;
    io.busy      = 1'b0;
    io.done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        io.done = (state_q == DONE);
        if (accept) begin
          state_d = (n_clamp != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        io.col_rd_en = 1'b1;
        io.busy      = 1'b1;
        if (last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        io.busy = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // sel_d tags the column whose data arrives next cycle; it is only set from RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      e_reg    <= '0;
      n_reg    <= '0;
      rank_reg <= '0;
      k        <= '0;
      sel_d    <= 1'b0;
      syn_q    <= '0;
      wt_q     <= '0;
    end else if (accept) begin
      e_reg    <= io.e_in;
      n_reg    <= n_clamp;
      rank_reg <= io.rank_in;
      k        <= '0;
      sel_d    <= 1'b0;
      syn_q    <= '0;
      wt_q     <= '0;
    end else begin
      sel_d <= (state_q == RUN) && e_reg[k];
      if ((state_q == RUN) && !last) begin
        k <= k + AW'(1);
      end
      if (sel_d) begin
        syn_q <= syn_q ^ (io.col_data & row_mask);
        wt_q  <= wt_q + NW'(1);
      end
    end
  end
endmodule

// File: tb/tb_syndrome_calc.sv
// Self-checking bench for syndrome_calc (RANK_MAX=8, N_ERR=16); column memory returns k+1.
`timescale 1ns/1ps
module tb_syndrome_calc;
  localparam int RM = 8;
  localparam int NE = 16;

  typedef struct {
    logic [7:0] syn;
    logic [4:0] w;
    int         lat;
    int         rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  int obs_lat, obs_rd_cnt, obs_rd_first, obs_addr_err, obs_busy_cnt, obs_busy_first;
  bit obs_timeout;

  syndrome_calc_if #(.RANK_MAX(RM), .N_ERR(NE)) io ();
  syndrome_calc #(.RANK_MAX(RM), .N_ERR(NE)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (io.col_rd_en) io.col_data <= {4'd0, io.col_addr} + 8'd1;
  end

  function automatic exp_t model(logic [15:0] e, logic [4:0] n, logic [3:0] rank);
    exp_t x;
    int nn = (n > 16) ? 16 : int'(n);
    logic [7:0] d;
    x.syn = 8'h00;
    x.w   = 5'd0;
    for (int kk = 0; kk < nn; kk++) begin
      if (e[kk]) begin
        d = 8'(kk + 1);
        for (int r = 0; r < 8; r++) if (r >= int'(rank)) d[r] = 1'b0;
        x.syn = x.syn ^ d;
        x.w   = x.w + 5'd1;
      end
    end
    x.lat = (nn > 0) ? nn + 2 : 1;
    x.rd  = nn;
    return x;
  endfunction

  // Drives one request, records what the DUT does until done (bounded), pushes the model result.
  task automatic run(input logic [15:0] e, input logic [4:0] n, input logic [3:0] rank, input bit pulse);
    int c = 0;
    sb.push_back(model(e, n, rank));
    @(negedge clk);
    io.e_in = e; io.n_cols_in = n; io.rank_in = rank; io.start = 1'b1;
    @(posedge clk);
    obs_lat = -1; obs_rd_cnt = 0; obs_rd_first = -1; obs_addr_err = 0;
    obs_busy_cnt = 0; obs_busy_first = -1; obs_timeout = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (c == 1) io.start = 1'b0;
      if (pulse && c == 2) io.start = 1'b1;
      if (pulse && c == 3) io.start = 1'b0;
      if (io.col_rd_en) begin
        if (io.col_addr !== 4'(obs_rd_cnt)) obs_addr_err++;
        if (obs_rd_cnt == 0) obs_rd_first = c;
        obs_rd_cnt++;
      end
      if (io.busy) begin
        if (obs_busy_cnt == 0) obs_busy_first = c;
        obs_busy_cnt++;
      end
      if (io.done) begin obs_lat = c; break; end
      if (c > 100) begin obs_timeout = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (io.syndrome !== 8'h00) begin fails++; $display("FAIL reset_syndrome: got %h want 00", io.syndrome); end
    tests++; if (io.err_weight !== 5'd0) begin fails++; $display("FAIL reset_weight: got %0d want 0", io.err_weight); end
    tests++; if (io.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", io.busy); end
    tests++; if (io.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", io.done); end
    tests++; if (io.col_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b want 0", io.col_rd_en); end
    tests++; if (io.col_addr !== 4'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", io.col_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    exp_t x;
    run(16'h0005, 5'd16, 4'd8, 1'b0);
    x = sb.pop_front();
    tests++; if (obs_timeout) begin fails++; $display("FAIL basic_timeout: done not seen, want at T+%0d", x.lat); end
    tests++; if (io.syndrome !== x.syn) begin fails++; $display("FAIL basic_syn: got %h want %h", io.syndrome, x.syn); end
    tests++; if (io.err_weight !== x.w) begin fails++; $display("FAIL basic_weight: got %0d want %0d", io.err_weight, x.w); end
    tests++; if (obs_lat != x.lat) begin fails++; $display("FAIL basic_latency: got %0d want %0d", obs_lat, x.lat); end
    tests++; if (obs_rd_cnt != 16 || obs_rd_first != 1) begin fails++; $display("FAIL basic_reads: got %0d from T+%0d want 16 from T+1", obs_rd_cnt, obs_rd_first); end
    tests++; if (obs_addr_err != 0) begin fails++; $display("FAIL basic_addr: got %0d out-of-order addresses want 0", obs_addr_err); end
    tests++; if (obs_busy_cnt != 17 || obs_busy_first != 1) begin fails++; $display("FAIL basic_busy: got %0d cycles from T+%0d want 17 from T+1", obs_busy_cnt, obs_busy_first); end
  endtask

  task automatic test_rank_mask;
    logic [15:0] ev [2] = '{16'h4000, 16'h8000};
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      run(ev[i], 5'd16, 4'd4, 1'b0);
      x = sb.pop_front();
      tests++; if (io.syndrome !== x.syn) begin fails++; $display("FAIL mask%0d_syn: got %h want %h", i, io.syndrome, x.syn); end
      tests++; if (io.err_weight !== x.w) begin fails++; $display("FAIL mask%0d_weight: got %0d want %0d", i, io.err_weight, x.w); end
    end
  endtask

  task automatic test_zero_cols;
    exp_t x;
    run(16'hFFFF, 5'd0, 4'd8, 1'b0);
    x = sb.pop_front();
    tests++; if (obs_lat != x.lat) begin fails++; $display("FAIL zero_latency: got %0d want %0d", obs_lat, x.lat); end
    tests++; if (io.syndrome !== x.syn || io.err_weight !== x.w) begin fails++; $display("FAIL zero_result: got %h/%0d want %h/%0d", io.syndrome, io.err_weight, x.syn, x.w); end
    tests++; if (obs_rd_cnt != 0) begin fails++; $display("FAIL zero_reads: got %0d want 0", obs_rd_cnt); end
  endtask

  task automatic test_start_ignored;
    exp_t x;
    run(16'hFFFF, 5'd3, 4'd8, 1'b1);
    x = sb.pop_front();
    tests++; if (obs_lat != x.lat) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", obs_lat, x.lat); end
    tests++; if (io.syndrome !== x.syn || io.err_weight !== x.w) begin fails++; $display("FAIL ignore_result: got %h/%0d want %h/%0d", io.syndrome, io.err_weight, x.syn, x.w); end
    tests++; if (obs_rd_cnt != 3 || obs_addr_err != 0) begin fails++; $display("FAIL ignore_reads: got %0d reads, %0d bad addr want 3, 0", obs_rd_cnt, obs_addr_err); end
  endtask

  task automatic test_boundaries;
    logic [15:0] ev [3] = '{16'hA5C3, 16'hFFFF, 16'h8001};
    logic [4:0]  nv [3] = '{5'd16, 5'd20, 5'd31};
    logic [3:0]  rv [3] = '{4'd0, 4'd15, 4'd7};
    exp_t x;
    for (int i = 0; i < 3; i++) begin
      run(ev[i], nv[i], rv[i], 1'b0);
      x = sb.pop_front();
      tests++; if (io.syndrome !== x.syn || io.err_weight !== x.w) begin fails++; $display("FAIL bound%0d_result: got %h/%0d want %h/%0d", i, io.syndrome, io.err_weight, x.syn, x.w); end
      tests++; if (obs_lat != x.lat || obs_rd_cnt != x.rd) begin fails++; $display("FAIL bound%0d_timing: got lat %0d rd %0d want %0d %0d", i, obs_lat, obs_rd_cnt, x.lat, x.rd); end
    end
  endtask

  task automatic test_back_to_back;
    exp_t x;
    for (int i = 0; i < 6; i++) begin
      run(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 15)), 1'b0);
      x = sb.pop_front();
      tests++; if (io.syndrome !== x.syn || io.err_weight !== x.w) begin fails++; $display("FAIL b2b%0d_result: got %h/%0d want %h/%0d", i, io.syndrome, io.err_weight, x.syn, x.w); end
      tests++; if (obs_lat != x.lat || obs_rd_cnt != x.rd) begin fails++; $display("FAIL b2b%0d_timing: got lat %0d rd %0d want %0d %0d", i, obs_lat, obs_rd_cnt, x.lat, x.rd); end
    end
  endtask

  task automatic test_rst_abort;
    exp_t x;
    @(negedge clk);
    io.e_in = 16'h0005; io.n_cols_in = 5'd16; io.rank_in = 4'd8; io.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) io.start = 1'b0;
      if (c == 5) rst = 1'b1;
    end
    tests++; if (io.syndrome !== 8'h00 || io.err_weight !== 5'd0) begin fails++; $display("FAIL abort_result: got %h/%0d want 00/0", io.syndrome, io.err_weight); end
    tests++; if (io.busy !== 1'b0 || io.done !== 1'b0 || io.col_rd_en !== 1'b0) begin fails++; $display("FAIL abort_ctrl: got busy %b done %b rd %b want 0 0 0", io.busy, io.done, io.col_rd_en); end
    tests++; if (io.col_addr !== 4'd0) begin fails++; $display("FAIL abort_addr: got %0d want 0", io.col_addr); end
    rst = 1'b0;
    run(16'h0005, 5'd16, 4'd8, 1'b0);
    x = sb.pop_front();
    tests++; if (io.syndrome !== x.syn || io.err_weight !== x.w || obs_lat != x.lat) begin fails++; $display("FAIL abort_rerun: got %h/%0d lat %0d want %h/%0d lat %0d", io.syndrome, io.err_weight, obs_lat, x.syn, x.w, x.lat); end
  endtask

  initial begin
    rst = 1'b1;
    io.start = 1'b0; io.e_in = '0; io.n_cols_in = '0; io.rank_in = '0; io.col_data = '0;
    test_reset();
    test_basic();
    test_rank_mask();
    test_zero_cols();
    test_start_ignored();
    test_boundaries();
    test_back_to_back();
    test_rst_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
